ycbcr2rgb: RTL and testbench
============================

Name: ycbcr2rgb

Overview:
- Pipelined YCbCr888 → RGB444 converter; the inverse of the front-end RGB444 → YCbCr colour-space conversion.
- Used to send YCbCr-domain processed frames (e.g. after Y/Cb/Cr adjustment or overlay) back to the RGB444 display/VGA path.
- Uses a valid/ready stream interface with full backpressure.
- Counts pixels whose result needed clamping, for threshold/debug observation on LEDs or the UART readout.

Parameters:
- SAT_CNT_W, 16, width of the saturation event counter.

Ports:
- clk  input  1  system clock; the block uses this single clock.
- rst  input  1  reset; synchronous and active-high.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input beat this cycle.
- ycbcr_in  input  24  {Y[23:16], Cb[15:8], Cr[7:0]}, unsigned 8-bit each.
- out_valid  output  1  imgPixel_out valid.
- out_ready  input  1  downstream accepts the output beat.
- imgPixel_out  output  12  RGB444 {R[11:8], G[7:4], B[3:0]}.
- sat_flag  output  1  current output beat had at least one channel clamped; qualified by out_valid.
- sat_cnt  output  SAT_CNT_W  number of accepted output beats with sat_flag=1.
- sat_clr  input  1  synchronous clear of sat_cnt.

Behaviour:
- Reset values: in_ready=0 while rst=1; out_valid=0; imgPixel_out=12'h000; sat_flag=0; sat_cnt=0. All stage valids clear. Reset mid-operation discards in-flight beats; no output beat follows a reset.
- Transfers:
  - An input transfer happens when in_valid && in_ready.
  - An output transfer happens when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, imgPixel_out and sat_flag hold stable.
- Pipeline: 3 stages (S1, S2, S3); S3 registers are the outputs.
  - Stage k loads when !v_k || adv_{k+1}; adv_4 = out_ready.
  - in_ready = !v1 || adv2, with combinational ready chain, no bubbles.
  - Latency is 3 cycles from input transfer to out_valid with out_ready held high.
  - Throughput is 1 beat/cycle.
  - With out_ready low, exactly 3 beats are buffered, then in_ready=0.
- S1 (offset):
  - Register Y (unsigned).
  - dCb = Cb − 128 and dCr = Cr − 128, each 9-bit signed, range −128..127.
- S2 (multiply-accumulate), 19-bit signed:
  - SR = (Y<<8) + 359·dCr + 128
  - SG = (Y<<8) − 88·dCb − 183·dCr + 128
  - SB = (Y<<8) + 454·dCb + 128
  - Coefficients: 1.402, 0.344, 0.714, 1.772 scaled by 256; +128 is the rounding term.
- S3 (shift, clamp, pack):
  - Each channel C8 = clamp(S >>> 8, 0, 255), using an arithmetic shift.
  - Pack C8[7:4] per channel (truncation).
  - sat_flag = any channel clamped (below 0 or above 255).
- sat_cnt:
  - Increments by 1 on each output transfer with sat_flag=1.
  - Sticks at all-ones; no wrap.
  - sat_clr has priority over increment; a coincident event is not counted.
- Simultaneous input and output transfer in the same cycle is legal and loses no beat.

Decomposition:
- Shared package (ycbcr_pkg): coefficients (359, 88, 183, 454), OFFSET_128, ROUND_HALF=128, SUM_W=19, and the packed YCbCr888 / RGB444 field positions.
- Same package is reused by the forward converter.
- One sub-module: ycc_clamp8. Takes a SUM_W signed input and returns an 8-bit clamped value plus a clamp flag. Instantiated ×3 in S3.

Test Plan:
- Y=128, Cb=128, Cr=128, out_ready=1 → imgPixel_out=12'h888, sat_flag=0, out_valid exactly 3 cycles after the input transfer.
- Y=255, Cb=128, Cr=255 → R clamped to 255, G=164, B=255 → 12'hFAF, sat_flag=1, sat_cnt=1. Then Y=0, Cb=0, Cr=128 → B clamped to 0, G=44, R=0 → 12'h020, sat_flag=1, sat_cnt=2.
- Y=76, Cb=85, Cr=255 → R=254, G=0, B=0 → 12'hF00, sat_flag=0, sat_cnt unchanged.
- out_ready=0 with 5 consecutive valid beats A..E → in_ready falls after 3 accepts and out_valid holds A stable. Then out_ready=1 → A..E delivered in order, none dropped or duplicated.
- Random out_ready and in_valid toggling over 1000 beats vs. reference model → exact data and order match; sat_cnt equals the model count.
- sat_cnt at all-ones stays saturated. sat_clr coincident with a saturating transfer → sat_cnt=0. rst asserted with 2 beats in flight → out_valid=0 the next cycle and no stale beat afterwards.

Source files
------------

// File: rtl/ycbcr_pkg.sv
// Shared YCbCr <-> RGB444 conversion constants and packed pixel layouts.
package ycbcr_pkg;

  localparam int SUM_W      = 19;
  localparam int OFFSET_128 = 128;
  localparam int ROUND_HALF = 128;

  // BT.601 coefficients scaled by 256
  localparam int COEF_R_CR = 359;  // 1.402
  localparam int COEF_G_CB = 88;   // 0.344
  localparam int COEF_G_CR = 183;  // 0.714
  localparam int COEF_B_CB = 454;  // 1.772

  // YCbCr888 field positions
  localparam int Y_MSB  = 23;
  localparam int Y_LSB  = 16;
  localparam int CB_MSB = 15;
  localparam int CB_LSB = 8;
  localparam int CR_MSB = 7;
  localparam int CR_LSB = 0;

  // RGB444 field positions
  localparam int R_MSB = 11;
  localparam int R_LSB = 8;
  localparam int G_MSB = 7;
  localparam int G_LSB = 4;
  localparam int B_MSB = 3;
  localparam int B_LSB = 0;

  typedef logic signed [SUM_W-1:0] sum_t;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } ycbcr888_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/ycc_clamp8.sv
// Drops the 8 fractional bits of a fixed-point channel sum and clamps to 0..255.
module ycc_clamp8
  import ycbcr_pkg::*;
(
  input  sum_t       sum_i,
  output logic [7:0] val_o,
  output logic       clamped_o
);

  sum_t sh;
  assign sh = sum_i >>> 8;

  // Saturate below zero and above 255, flag either case
  always_comb begin
    val_o     = sh[7:0];
    clamped_o = 1'b0;
    if (sh < sum_t'(0)) begin
      val_o     = 8'h00;
      clamped_o = 1'b1;
    end else if (sh > sum_t'(255)) begin
      val_o     = 8'hFF;
      clamped_o = 1'b1;
    end
  end

endmodule

// File: rtl/ycbcr2rgb.sv
// Three-stage YCbCr888 -> RGB444 converter with valid/ready backpressure
// and a sticky count of output beats that needed clamping.
module ycbcr2rgb
  import ycbcr_pkg::*;
#(
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [23:0]          ycbcr_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [11:0]          imgPixel_out,
  output logic                 sat_flag,
  output logic [SAT_CNT_W-1:0] sat_cnt,
  input  logic                 sat_clr
);

  logic              v1_q, v2_q, v3_q;
  logic        [7:0] y1_q;
  logic signed [8:0] dcb1_q, dcr1_q;
  sum_t              sr2_q, sg2_q, sb2_q;
  logic       [11:0] pix3_q;
  logic              sat3_q;
  logic [SAT_CNT_W-1:0] sat_cnt_q;

  logic ld1, ld2, ld3;
  ycbcr888_t pix_in;

  assign pix_in = ycbcr888_t'(ycbcr_in);

  // Ready chain: a stage loads when empty or when its successor takes its beat
  assign ld3      = !v3_q || out_ready;
  assign ld2      = !v2_q || ld3;
  assign ld1      = !v1_q || ld2;
  assign in_ready = ld1 && !rst;

  // S1: remove the chroma offset
  logic signed [8:0] dcb_d, dcr_d;
  assign dcb_d = $signed({1'b0, pix_in.cb}) - 9'sd128;
  assign dcr_d = $signed({1'b0, pix_in.cr}) - 9'sd128;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      y1_q   <= '0;
      dcb1_q <= '0;
      dcr1_q <= '0;
    end else if (ld1) begin
      v1_q   <= in_valid;
      y1_q   <= pix_in.y;
      dcb1_q <= dcb_d;
      dcr1_q <= dcr_d;
    end
  end

  // S2: fixed-point multiply-accumulate with rounding bias
  sum_t y_sh, dcb_x, dcr_x, sr_d, sg_d, sb_d;
  assign y_sh  = sum_t'({y1_q, 8'h00});
  assign dcb_x = sum_t'(dcb1_q);
  assign dcr_x = sum_t'(dcr1_q);
  assign sr_d  = y_sh + sum_t'(COEF_R_CR) * dcr_x + sum_t'(ROUND_HALF);
  assign sg_d  = y_sh - sum_t'(COEF_G_CB) * dcb_x - sum_t'(COEF_G_CR) * dcr_x
               + sum_t'(ROUND_HALF);
  assign sb_d  = y_sh + sum_t'(COEF_B_CB) * dcb_x + sum_t'(ROUND_HALF);

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q  <= 1'b0;
      sr2_q <= '0;
      sg2_q <= '0;
      sb2_q <= '0;
    end else if (ld2) begin
      v2_q  <= v1_q;
      sr2_q <= sr_d;
      sg2_q <= sg_d;
      sb2_q <= sb_d;
    end
  end

  // S3: shift, clamp and pack the upper nibble of each channel
  logic [7:0] r8, g8, b8;
  logic       r_c, g_c, b_c;
  rgb444_t    pix_d;

  ycc_clamp8 u_clamp_r (.sum_i(sr2_q), .val_o(r8), .clamped_o(r_c));
  ycc_clamp8 u_clamp_g (.sum_i(sg2_q), .val_o(g8), .clamped_o(g_c));
  ycc_clamp8 u_clamp_b (.sum_i(sb2_q), .val_o(b8), .clamped_o(b_c));

  assign pix_d = '{r: r8[7:4], g: g8[7:4], b: b8[7:4]};

  always_ff @(posedge clk) begin
    if (rst) begin
      v3_q   <= 1'b0;
      pix3_q <= '0;
      sat3_q <= 1'b0;
    end else if (ld3) begin
      v3_q   <= v2_q;
      pix3_q <= pix_d;
      sat3_q <= v2_q && (r_c || g_c || b_c);
    end
  end

  // Saturation event counter; clear wins over a coincident event, sticks at max
  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      sat_cnt_q <= '0;
    end else if (v3_q && out_ready && sat3_q && (sat_cnt_q != {SAT_CNT_W{1'b1}})) begin
      sat_cnt_q <= sat_cnt_q + 1'b1;
    end
  end

  assign out_valid    = v3_q;
  assign imgPixel_out = pix3_q;
  assign sat_flag     = sat3_q;
  assign sat_cnt      = sat_cnt_q;

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Scoreboard bench for ycbcr2rgb: stimulus pushes expected beats, monitor pops and compares.
module tb_ycbcr2rgb;

  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [23:0]   ycbcr_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [11:0]   imgPixel_out;
  logic          sat_flag;
  logic [CW-1:0] sat_cnt;
  logic          sat_clr = 1'b0;

  logic ready_ctrl = 1'b1;
  logic rand_rdy   = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [12:0] sb[$];          // {sat, pix}
  logic [CW-1:0] mcnt = '0;

  logic        hold_pend = 1'b0;
  logic [11:0] hold_pix;
  logic        hold_sat;

  ycbcr2rgb #(.SAT_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ycbcr_in(ycbcr_in), .out_valid(out_valid), .out_ready(out_ready),
    .imgPixel_out(imgPixel_out), .sat_flag(sat_flag), .sat_cnt(sat_cnt),
    .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    out_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : ready_ctrl;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic logic [12:0] model(input logic [23:0] d);
    int y, dcb, dcr, s[3], c;
    logic [11:0] pix;
    logic sat;
    y   = int'(d[23:16]);
    dcb = int'(d[15:8]) - 128;
    dcr = int'(d[7:0]) - 128;
    s[0] = y * 256 + 359 * dcr + 128;
    s[1] = y * 256 - 88 * dcb - 183 * dcr + 128;
    s[2] = y * 256 + 454 * dcb + 128;
    sat = 1'b0;
    pix = '0;
    for (int k = 0; k < 3; k++) begin
      c = s[k] >>> 8;
      if (c < 0) begin c = 0; sat = 1'b1; end
      else if (c > 255) begin c = 255; sat = 1'b1; end
      pix = {pix[7:0], c[7:4]};
    end
    return {sat, pix};
  endfunction

  // Monitor: compare each output transfer against the scoreboard, check holds, track sat count
  always @(negedge clk) begin
    logic [12:0] e;
    logic        xsat;
    if (rst) begin
      mcnt = '0;
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_pix", 32'(imgPixel_out), 32'(hold_pix));
        chk("hold_sat", 32'(sat_flag), 32'(hold_sat));
      end
      hold_pend = out_valid && !out_ready;
      hold_pix  = imgPixel_out;
      hold_sat  = sat_flag;
      xsat = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected none at %0t", imgPixel_out, $time);
        end else begin
          e = sb.pop_front();
          chk("out_pix", 32'(imgPixel_out), 32'(e[11:0]));
          chk("out_sat", 32'(sat_flag), 32'(e[12]));
          xsat = e[12];
        end
      end
      if (sat_clr) mcnt = '0;
      else if (xsat && mcnt != CMAX) mcnt = mcnt + 1'b1;
    end
  end

  // Present one beat and hold it until accepted; leaves in_valid high
  task automatic send(input logic [23:0] d, input logic [12:0] exp);
    logic acc;
    int n;
    in_valid = 1'b1;
    ycbcr_in = d;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (acc) sb.push_back(exp);
    else timeout("send_accept");
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) timeout("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
  endtask

  initial begin
    logic [23:0] bp_vec[5];
    logic [12:0] bp_exp[5];
    int acc, lat, seen;
    logic a;
    logic [31:0] r;

    bp_vec[0] = 24'h808080; bp_exp[0] = {1'b0, 12'h888};
    bp_vec[1] = 24'hFF80FF; bp_exp[1] = {1'b1, 12'hFAF};
    bp_vec[2] = 24'h000080; bp_exp[2] = {1'b1, 12'h020};
    bp_vec[3] = 24'h4C55FF; bp_exp[3] = {1'b0, 12'hF00};
    bp_vec[4] = 24'h808080; bp_exp[4] = {1'b0, 12'h888};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pix", 32'(imgPixel_out), 32'h000);
    chk("rst_sat_flag", 32'(sat_flag), 32'd0);
    chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_ctrl = 1'b1;
    idle(2);

    // Mid-grey, with latency measurement
    send(24'h808080, {1'b0, 12'h888});
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    drain();
    chk("sat_cnt_grey", 32'(sat_cnt), 32'd0);

    send(24'hFF80FF, {1'b1, 12'hFAF});
    drain();
    chk("sat_cnt_hi", 32'(sat_cnt), 32'd1);
    send(24'h000080, {1'b1, 12'h020});
    drain();
    chk("sat_cnt_lo", 32'(sat_cnt), 32'd2);
    send(24'h4C55FF, {1'b0, 12'hF00});
    drain();
    chk("sat_cnt_edge", 32'(sat_cnt), 32'd2);

    // Backpressure: five beats offered, only three fit
    ready_ctrl = 1'b0;
    idle(2);
    acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      ycbcr_in = bp_vec[acc];
      @(negedge clk);
      a = in_ready;
      @(posedge clk);
      #1;
      if (a) begin
        sb.push_back(bp_exp[acc]);
        acc++;
      end
    end
    chk("bp_accepted", 32'(acc), 32'd3);
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_head_pix", 32'(imgPixel_out), 32'h888);
    @(posedge clk);
    #1;
    ready_ctrl = 1'b1;
    send(bp_vec[3], bp_exp[3]);
    send(bp_vec[4], bp_exp[4]);
    drain();

    // Counter sticks at all-ones
    clr_pulse();
    for (int i = 0; i < 17; i++) send(24'hFF80FF, {1'b1, 12'hFAF});
    drain();
    chk("sat_cnt_stick", 32'(sat_cnt), 32'(CMAX));

    // Clear coincident with a saturating output transfer
    ready_ctrl = 1'b0;
    send(24'hFF80FF, {1'b1, 12'hFAF});
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 20) begin
      @(posedge clk);
      #1;
      seen++;
    end
    if (!out_valid) timeout("clr_wait");
    sat_clr = 1'b1;
    ready_ctrl = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    chk("clr_priority", 32'(sat_cnt), 32'd0);
    drain();

    // Reset with two beats in flight
    send(24'h808080, {1'b0, 12'h888});
    send(24'h4C55FF, {1'b0, 12'hF00});
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    chk("rst_flight_valid", 32'(out_valid), 32'd0);
    chk("rst_flight_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_no_stale", 32'(seen), 32'd0);
    @(posedge clk);
    #1;

    // Random traffic against the reference model
    clr_pulse();
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      r = $urandom;
      send(r[23:0], model(r[23:0]));
    end
    rand_rdy = 1'b0;
    ready_ctrl = 1'b1;
    drain();
    chk("sat_cnt_random", 32'(sat_cnt), 32'(mcnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
